// File: rtl/mmm_sequencer.sv
// Initiator-side sequencer for the Montgomery modular multiplier: walks the datapath
// through clear/load/iterate/capture and applies the final conditional subtraction.
module mmm_sequencer #(
   parameter int WIDTH = 10,
   parameter int ITER  = 10,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] m,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic             mmm_rst_n,
   output logic             mmm_ld_a,
   output logic             mmm_en,
   output logic             mmm_ld_r,
   output logic             mmm_lock,
   output logic [WIDTH-1:0] mmm_a,
   output logic [WIDTH-1:0] mmm_b,
   output logic [WIDTH-1:0] mmm_m,
   input  logic [WIDTH-1:0] mmm_r
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_RUN,
      S_CAPTURE,
      S_WAIT,
      S_REDUCE,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_d;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic             rst_n_q;
   logic             ld_a_q;
   logic             en_q;
   logic             ld_r_q;
   logic             lock_q;
   logic             accept_d;
   logic             reject_d;

   // Multiplier output is below 2M, so one subtraction fully reduces it.
   function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH-1:0] r,
                                                 input logic [WIDTH-1:0] md);
      logic [WIDTH:0] diff;
      diff = {1'b0, r} - {1'b0, md};
      return diff[WIDTH] ? r : diff[WIDTH-1:0];
   endfunction

   always_comb begin
      cnt_d    = cnt_q + 1'b1;
      result_d = cond_sub(mmm_r, m_q);
      accept_d = start && m[0];
      reject_d = start && !m[0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         m_q      <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rst_n_q  <= 1'b1;
         ld_a_q   <= 1'b0;
         en_q     <= 1'b0;
         ld_r_q   <= 1'b0;
         lock_q   <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rst_n_q <= 1'b1;
         ld_a_q  <= 1'b0;
         en_q    <= 1'b0;
         ld_r_q  <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               // Outputs are registered, so each branch sets the values of the state it enters.
               if (accept_d) begin
                  a_q     <= a;
                  b_q     <= b;
                  m_q     <= m;
                  busy_q  <= 1'b1;
                  rst_n_q <= 1'b0;
                  lock_q  <= 1'b0;
                  state_q <= S_CLEAR;
               end else begin
                  err_q   <= reject_d;
                  state_q <= S_IDLE;
               end
            end
            S_CLEAR: begin
               ld_a_q  <= 1'b1;
               en_q    <= 1'b1;
               state_q <= S_LOAD;
            end
            S_LOAD: begin
               cnt_q   <= '0;
               en_q    <= 1'b1;
               state_q <= S_RUN;
            end
            S_RUN: begin
               cnt_q <= cnt_d;
               if (cnt_q == CNT_W'(ITER - 1)) begin
                  ld_r_q  <= 1'b1;
                  state_q <= S_CAPTURE;
               end else begin
                  en_q    <= 1'b1;
               end
            end
            S_CAPTURE: begin
               lock_q  <= 1'b1;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               state_q <= S_REDUCE;
            end
            S_REDUCE: begin
               result_q <= result_d;
               busy_q   <= 1'b0;
               done_q   <= 1'b1;
               state_q  <= S_DONE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign result    = result_q;
   assign mmm_rst_n = rst_n_q;
   assign mmm_ld_a  = ld_a_q;
   assign mmm_en    = en_q;
   assign mmm_ld_r  = ld_r_q;
   assign mmm_lock  = lock_q;
   assign mmm_a     = a_q;
   assign mmm_b     = b_q;
   assign mmm_m     = m_q;

endmodule
